tournament_chooser_ctrl: RTL and testbench
==========================================

// Module: tournament_chooser_ctrl
// PURPOSE
//  Parametrised tournament (meta) predictor controller for the fetch stage. Chooses
//  between local and global direction predictions with a per-PC saturating chooser
//  table and forms the next-fetch redirect from RAS, BTB and fall-through. Tracks
//  in-flight predictions in a FIFO and checks each one against ID resolution.
//  On a mispredict it flushes, redirects and keeps the delay-slot entries.
// PARAMETERS
//  IDX_W      10  chooser table index width (2**IDX_W entries, index = IF_PC[IDX_W+1:2])
//  CTR_W       2  chooser counter width (>=1)
//  Q_DEPTH     8  in-flight prediction FIFO depth (>=2, power of 2)
//  KEEP_SLOTS  1  oldest entries retained after a mispredict (branch delay slots, < Q_DEPTH)
//  CNT_W      32  performance counter width
// PORTS
//  CLK            in   1   clock
//  RESET          in   1   asynchronous, active-low reset
//  STALL          in   1   pipeline stall; all state freezes while high
//  if_valid       in   1   IF_PC is a real fetch this cycle
//  IF_PC          in   32  fetch PC
//  pred_l         in   1   local predictor taken
//  pred_g         in   1   global predictor taken
//  btb_hit        in   1   BTB hit for IF_PC
//  btb_target     in   32  BTB target
//  ras_hit        in   1   RAS hit for IF_PC
//  ras_target     in   32  RAS target
//  id_valid       in   1   an instruction resolves in ID this cycle (pops one entry)
//  id_is_branch   in   1   the resolving instruction is a conditional branch
//  ID_PC          in   32  PC of the resolving instruction
//  id_taken       in   1   actual direction
//  id_target      in   32  actual taken target
//  flush          out  1   squash younger fetched instructions
//  request_alt_pc out  1   fetch must use alt_address next
//  alt_address    out  32  next-fetch address
//  fetch_hold     out  1   FIFO full; fetch must not advance (combinational)
//  underflow_err  out  1   sticky: id_valid arrived with FIFO empty
//  branch_cnt     out  CNT_W  resolved branches (saturating)
//  mispred_cnt    out  CNT_W  mispredicts (saturating)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, every chooser counter = 2**(CTR_W-1)-1 (weak local).
//  Choice: the counter MSB selects the source; 1 -> pred_g, 0 -> pred_l.
//  Next PC (registered, 1-cycle latency), by priority:
//   mispredict -> corrected address; else ras_hit -> ras_target;
//   else btb_hit & chosen taken -> btb_target; else IF_PC+4.
//   request_alt_pc = 1 on mispredict, ras_hit, or btb_hit & chosen taken.
//  Push: if_valid & !STALL & !mispredict & (!full | pop). The entry holds
//   {IF_PC, pred_l, pred_g, chosen, next_pc}.
//  Pop: id_valid & !STALL & !empty. Only the head entry is checked.
//  Mispredict: pop & id_is_branch & head.next_pc != (id_taken ? id_target : ID_PC+8).
//   Corrected address = id_taken ? id_target : ID_PC+8.
//   Next cycle: flush=1, request_alt_pc=1, alt_address=corrected address.
//   FIFO keeps the KEEP_SLOTS oldest entries after the head and drops the rest.
//   The same-cycle IF push is dropped. mispred_cnt += 1.
//  Non-mispredict cycle: flush=0.
//  Chooser update: on pop & id_is_branch & head.pred_l != head.pred_g only.
//   Increment (saturate at max) if head.pred_g == id_taken, else decrement (saturate at 0).
//   Index comes from head.IF_PC, not ID_PC.
//  Same-index read and write in one cycle: the read returns the old value.
//  Full with simultaneous pop and push: allowed; occupancy unchanged.
//  Empty with id_valid: no pop, no check, underflow_err <= 1 (cleared only by reset).
//  STALL=1: no push/pop/update/counter change; outputs hold their values.
//  Counters saturate at all-ones. Address arithmetic is mod 2**32.
//  RESET low mid-operation: immediate async clear of FIFO, table, counters and outputs.
// STRUCTURE
//  bp_pkg: entry struct/typedef, counter init constant, PC_INC=4, SLOT_INC=8.
//  Sub-module chooser_table (2**IDX_W x CTR_W counters, 1 read + 1 update port,
//   async-reset init). FIFO, redirect logic and counters are inline.
// TESTING
//  1 Reset, then IF_PC=0x100 btb_hit target 0x200, pred_l=1 pred_g=0
//    -> next cycle request_alt_pc=1, alt_address=0x200 (weak local chosen).
//  2 Same branch resolves id_taken=0, ID_PC=0x100 -> flush=1, alt_address=0x108,
//    entry 0x104 kept, younger entries gone, mispred_cnt=1, counter 0x40 -> 2 (now global).
//  3 Fill FIFO with Q_DEPTH pushes, no pops -> fetch_hold=1, 9th push dropped.
//    Then pop+push in the same cycle -> occupancy stays 8.
//  4 pred_l==pred_g on a resolved branch -> chooser counter unchanged.
//  5 Hold STALL=1 for 3 cycles with id_valid/if_valid active -> no state or output change.
//  6 id_valid with FIFO empty -> underflow_err=1 until RESET; assert RESET mid-fill -> all zero.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the tournament chooser controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bp_pkg;

    // Fall-through fetch increment and not-taken resolution increment (past the delay slot)
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] SLOT_INC = 32'd8;

    // One in-flight prediction, checked when its instruction resolves in ID
    typedef struct packed {
        logic [31:0] pc;
        logic        pred_l;
        logic        pred_g;
        logic        chosen;
        logic [31:0] next_pc;
    } entry_t;

    // Reset value of a chooser counter: weakest "use local" state
    function automatic int unsigned ctr_init(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/chooser_table.sv
// Per-PC saturating chooser counters; one combinational read port, one update port.
// Latency: read is combinational (returns pre-update value), update lands next edge.
// Backpressure: none; caller gates upd_en.
module chooser_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int CTR_W = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_sel_g,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_inc
);

    localparam int              DEPTH    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

    logic [CTR_W-1:0] ctr_q [DEPTH];
    logic [CTR_W-1:0] upd_old;

    // Counter MSB picks the global predictor
    assign rd_sel_g = ctr_q[rd_idx][CTR_W-1];
    assign upd_old  = ctr_q[upd_idx];

    // Saturating increment/decrement of the addressed counter
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            if (upd_inc) begin
                if (upd_old != CTR_MAX) begin
                    ctr_q[upd_idx] <= upd_old + CTR_ONE;
                end
            end else if (upd_old != '0) begin
                ctr_q[upd_idx] <= upd_old - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/tournament_chooser_ctrl.sv
// Tournament predictor controller: chooses local/global, forms next fetch PC, checks predictions at ID.
// Latency: redirect/flush outputs registered, 1 cycle after the deciding inputs.
// Backpressure: fetch_hold (combinational) while the in-flight FIFO is full; STALL freezes all state.
module tournament_chooser_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W      = 10,
    parameter int CTR_W      = 2,
    parameter int Q_DEPTH    = 8,
    parameter int KEEP_SLOTS = 1,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             if_valid,
    input  logic [31:0]      IF_PC,
    input  logic             pred_l,
    input  logic             pred_g,
    input  logic             btb_hit,
    input  logic [31:0]      btb_target,
    input  logic             ras_hit,
    input  logic [31:0]      ras_target,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic [31:0]      ID_PC,
    input  logic             id_taken,
    input  logic [31:0]      id_target,
    output logic             flush,
    output logic             request_alt_pc,
    output logic [31:0]      alt_address,
    output logic             fetch_hold,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int             PTR_W     = $clog2(Q_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(Q_DEPTH);
    localparam logic [PTR_W:0] KEEP_CNT  = (PTR_W + 1)'(KEEP_SLOTS);
    localparam logic [PTR_W:0] ONE_CNT   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);
    localparam logic [CNT_W-1:0] ONE_PERF = CNT_W'(1);

    entry_t           fifo_q [Q_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    entry_t           head;
    entry_t           push_entry;
    logic             full;
    logic             empty;
    logic             sel_g;
    logic             chosen;
    logic             pop;
    logic             push;
    logic             mispredict;
    logic             take_alt;
    logic [31:0]      corrected;
    logic [31:0]      next_pc;
    logic [PTR_W:0]   after_pop;
    logic [PTR_W:0]   keep_cnt;
    logic             upd_en;
    logic             upd_inc;
    logic             unused_bits;

    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign fetch_hold = full;
    assign head       = fifo_q[rd_ptr];

    chooser_table #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_chooser (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_idx   (IF_PC[IDX_W+1:2]),
        .rd_sel_g (sel_g),
        .upd_en   (upd_en),
        .upd_idx  (head.pc[IDX_W+1:2]),
        .upd_inc  (upd_inc)
    );

    // Choice, head check, redirect priority and FIFO control decisions
    always_comb begin
        chosen     = sel_g ? pred_g : pred_l;
        corrected  = id_taken ? id_target : (ID_PC + SLOT_INC);
        pop        = id_valid & ~STALL & ~empty;
        mispredict = pop & id_is_branch & (head.next_pc != corrected);
        take_alt   = mispredict | ras_hit | (btb_hit & chosen);
        next_pc    = IF_PC + PC_INC;
        if (mispredict) begin
            next_pc = corrected;
        end else if (ras_hit) begin
            next_pc = ras_target;
        end else if (btb_hit & chosen) begin
            next_pc = btb_target;
        end
        push       = if_valid & ~STALL & ~mispredict & (~full | pop);
        after_pop  = count - ONE_CNT;
        keep_cnt   = (after_pop > KEEP_CNT) ? KEEP_CNT : after_pop;
        upd_en     = pop & id_is_branch & (head.pred_l != head.pred_g);
        upd_inc    = (head.pred_g == id_taken);
    end

    assign push_entry = '{pc: IF_PC, pred_l: pred_l, pred_g: pred_g, chosen: chosen, next_pc: next_pc};

    // Entry fields not needed by the resolve-side check
    assign unused_bits = ^{head.pc[31:IDX_W+2], head.pc[1:0], head.chosen};

    // FIFO storage write
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers/occupancy; a mispredict trims to the delay-slot entries behind the head
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            rd_ptr <= rd_ptr + ONE_PTR;
            wr_ptr <= rd_ptr + ONE_PTR + keep_cnt[PTR_W-1:0];
            count  <= keep_cnt;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            if (push & ~pop) begin
                count <= count + ONE_CNT;
            end else if (pop & ~push) begin
                count <= count - ONE_CNT;
            end
        end
    end

    // Registered redirect outputs, sticky underflow and saturating perf counters
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            flush          <= 1'b0;
            request_alt_pc <= 1'b0;
            alt_address    <= '0;
            underflow_err  <= 1'b0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else if (!STALL) begin
            flush          <= mispredict;
            request_alt_pc <= take_alt;
            alt_address    <= next_pc;
            if (id_valid & empty) begin
                underflow_err <= 1'b1;
            end
            if (pop & id_is_branch & (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + ONE_PERF;
            end
            if (mispredict & (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + ONE_PERF;
            end
        end
    end

endmodule

// File: tb/tb_tournament_chooser_ctrl.sv
// Directed bench with a queue-based reference model compared every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_tournament_chooser_ctrl;

    localparam int QD   = 8;
    localparam int KEEP = 1;
    localparam int TBL  = 1024;

    logic        CLK, RESET, STALL;
    logic        if_valid, pred_l, pred_g, btb_hit, ras_hit;
    logic [31:0] IF_PC, btb_target, ras_target;
    logic        id_valid, id_is_branch, id_taken;
    logic [31:0] ID_PC, id_target;
    logic        flush, request_alt_pc, fetch_hold, underflow_err;
    logic [31:0] alt_address, branch_cnt, mispred_cnt;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    tournament_chooser_ctrl #(
        .IDX_W(10), .CTR_W(2), .Q_DEPTH(QD), .KEEP_SLOTS(KEEP), .CNT_W(32)
    ) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL),
        .if_valid(if_valid), .IF_PC(IF_PC), .pred_l(pred_l), .pred_g(pred_g),
        .btb_hit(btb_hit), .btb_target(btb_target), .ras_hit(ras_hit), .ras_target(ras_target),
        .id_valid(id_valid), .id_is_branch(id_is_branch), .ID_PC(ID_PC),
        .id_taken(id_taken), .id_target(id_target),
        .flush(flush), .request_alt_pc(request_alt_pc), .alt_address(alt_address),
        .fetch_hold(fetch_hold), .underflow_err(underflow_err),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        bit          pl;
        bit          pg;
        logic [31:0] nxt;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_ch [TBL];
    bit          m_flush, m_req, m_under;
    logic [31:0] m_alt, m_br, m_mis;

    task automatic m_reset();
        mq.delete();
        for (int i = 0; i < TBL; i++) m_ch[i] = 1;
        m_flush = 0; m_req = 0; m_under = 0;
        m_alt = 0; m_br = 0; m_mis = 0;
    endtask

    task automatic m_step();
        int          idx, hidx;
        bit          ch, pop, mis, was_full;
        logic [31:0] corr, nxt;
        m_ent_t      h;
        idx      = int'((IF_PC >> 2) % 32'd1024);
        ch       = (m_ch[idx] >= 2) ? pred_g : pred_l;
        corr     = id_taken ? id_target : ID_PC + 32'd8;
        was_full = (mq.size() == QD);
        pop      = id_valid && (mq.size() > 0);
        mis      = 0;
        if (id_valid && mq.size() == 0) m_under = 1;
        if (pop) begin
            h = mq.pop_front();
            if (id_is_branch) begin
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                mis = (h.nxt != corr);
                if (h.pl != h.pg) begin
                    hidx = int'((h.pc >> 2) % 32'd1024);
                    if (h.pg == id_taken) m_ch[hidx] = (m_ch[hidx] < 3) ? m_ch[hidx] + 1 : 3;
                    else                  m_ch[hidx] = (m_ch[hidx] > 0) ? m_ch[hidx] - 1 : 0;
                end
                if (mis) begin
                    if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
                    while (mq.size() > KEEP) void'(mq.pop_back());
                end
            end
        end
        if (mis)                 nxt = corr;
        else if (ras_hit)        nxt = ras_target;
        else if (btb_hit && ch)  nxt = btb_target;
        else                     nxt = IF_PC + 32'd4;
        if (if_valid && !mis && (!was_full || pop))
            mq.push_back('{IF_PC, pred_l, pred_g, nxt});
        m_flush = mis;
        m_req   = mis || ras_hit || (btb_hit && ch);
        m_alt   = nxt;
    endtask

    always @(posedge CLK or negedge RESET) begin
        if (!RESET)      m_reset();
        else if (!STALL) m_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m.flush",     {31'd0, flush},          {31'd0, m_flush});
            chk("m.req",       {31'd0, request_alt_pc}, {31'd0, m_req});
            chk("m.alt",       alt_address,             m_alt);
            chk("m.hold",      {31'd0, fetch_hold},     {31'd0, (mq.size() == QD)});
            chk("m.underflow", {31'd0, underflow_err},  {31'd0, m_under});
            chk("m.branch",    branch_cnt,              m_br);
            chk("m.mispred",   mispred_cnt,             m_mis);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        STALL = 0; if_valid = 0; IF_PC = 0; pred_l = 0; pred_g = 0;
        btb_hit = 0; btb_target = 0; ras_hit = 0; ras_target = 0;
        id_valid = 0; id_is_branch = 0; ID_PC = 0; id_taken = 0; id_target = 0;
    endtask

    task automatic setf(input logic [31:0] pc, input bit pl, input bit pg,
                        input bit bh, input logic [31:0] bt,
                        input bit rh, input logic [31:0] rt);
        if_valid = 1; IF_PC = pc; pred_l = pl; pred_g = pg;
        btb_hit = bh; btb_target = bt; ras_hit = rh; ras_target = rt;
    endtask

    task automatic setr(input logic [31:0] pc, input bit br, input bit tk, input logic [31:0] tgt);
        id_valid = 1; ID_PC = pc; id_is_branch = br; id_taken = tk; id_target = tgt;
    endtask

    task automatic chk_redirect(input string name, input bit fl, input bit rq, input logic [31:0] a);
        chk({name, ".flush"}, {31'd0, flush},          {31'd0, fl});
        chk({name, ".req"},   {31'd0, request_alt_pc}, {31'd0, rq});
        chk({name, ".alt"},   alt_address,             a);
    endtask

    initial begin
        RESET = 1;
        idle();
        #1 RESET = 0;
        chk_en = 1;
        repeat (2) tick();
        chk_redirect("reset", 0, 0, 32'h0);
        chk("reset.hold", {31'd0, fetch_hold}, 32'd0);
        chk("reset.mispred", mispred_cnt, 32'd0);
        @(negedge CLK) RESET = 1;

        // 1: weak local chooses pred_l=1 -> BTB redirect
        idle(); setf(32'h100, 1, 0, 1, 32'h200, 0, 0); tick();
        chk_redirect("t1", 0, 1, 32'h200);
        for (int i = 1; i <= 3; i++) begin
            idle(); setf(32'h100 + 32'(4 * i), 0, 0, 0, 0, 0, 0); tick();
        end

        // 2: not-taken resolution of 0x100 mispredicts; same-cycle push dropped
        idle(); setr(32'h100, 1, 0, 0); setf(32'h110, 0, 0, 0, 0, 0, 0); tick();
        chk_redirect("t2.mis", 1, 1, 32'h108);
        chk("t2.mispred", mispred_cnt, 32'd1);
        chk("t2.branch", branch_cnt, 32'd1);
        idle(); tick();
        chk("t2.flush_clear", {31'd0, flush}, 32'd0);
        // counter 0x40 now 2 -> global chosen
        idle(); setf(32'h100, 0, 1, 1, 32'h200, 0, 0); tick();
        chk_redirect("t2.global", 0, 1, 32'h200);
        // head must be the kept 0x104 entry (predicted 0x108)
        idle(); setr(32'h104, 1, 1, 32'h108); tick();
        chk_redirect("t2.kept", 0, 0, 32'h4);
        chk("t2.kept_mis", mispred_cnt, 32'd1);
        idle(); setr(32'h100, 1, 1, 32'h200); tick();
        chk("t2.branch2", branch_cnt, 32'd3);
        chk("t2.nomis", {31'd0, flush}, 32'd0);

        // 3: fill, overflow drop, simultaneous pop+push
        for (int i = 0; i < QD; i++) begin
            idle(); setf(32'h400 + 32'(4 * i), 0, 0, 0, 0, 0, 0); tick();
            if (i == QD - 2) chk("t3.hold7", {31'd0, fetch_hold}, 32'd0);
        end
        chk("t3.hold8", {31'd0, fetch_hold}, 32'd1);
        idle(); setf(32'h420, 0, 0, 0, 0, 0, 0); tick();
        chk("t3.hold9", {31'd0, fetch_hold}, 32'd1);
        idle(); setr(32'h400, 0, 0, 0); setf(32'h424, 0, 0, 0, 0, 0, 0); tick();
        chk("t3.poppush", {31'd0, fetch_hold}, 32'd1);
        for (int i = 1; i < QD; i++) begin
            idle(); setr(32'h400 + 32'(4 * i), 0, 0, 0); tick();
            if (i == 1) chk("t3.hold_drop", {31'd0, fetch_hold}, 32'd0);
        end
        idle(); setr(32'h424, 1, 1, 32'h428); tick();
        chk("t3.last", mispred_cnt, 32'd1);
        chk("t3.branch", branch_cnt, 32'd4);

        // 4: agreeing predictors leave the counter untouched
        idle(); setf(32'h300, 1, 1, 1, 32'h380, 0, 0); tick();
        chk_redirect("t4.pred", 0, 1, 32'h380);
        idle(); setr(32'h300, 1, 1, 32'h380); tick();
        idle(); setf(32'h300, 1, 0, 1, 32'h380, 0, 0); tick();
        chk_redirect("t4.still_local", 0, 1, 32'h380);
        idle(); setr(32'h300, 0, 0, 0); tick();
        // RAS beats BTB
        idle(); setf(32'h500, 1, 1, 1, 32'h700, 1, 32'h600); tick();
        chk_redirect("t4.ras", 0, 1, 32'h600);
        idle(); setr(32'h500, 0, 0, 0); tick();

        // 5: STALL freezes everything
        idle(); setf(32'h800, 0, 0, 0, 0, 0, 0); tick();
        chk_redirect("t5.pre", 0, 0, 32'h804);
        idle(); STALL = 1; setf(32'h900, 1, 1, 1, 32'h990, 1, 32'h998); setr(32'h800, 1, 1, 32'hABC);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_redirect("t5.stall", 0, 0, 32'h804);
            chk("t5.branch", branch_cnt, 32'd5);
            chk("t5.mispred", mispred_cnt, 32'd1);
        end
        idle(); setr(32'h800, 0, 0, 0); tick();
        chk("t5.resume", {31'd0, underflow_err}, 32'd0);

        // 6: underflow is sticky; async reset mid-fill clears all
        idle(); setr(32'h0, 1, 0, 0); tick();
        chk("t6.under", {31'd0, underflow_err}, 32'd1);
        chk("t6.branch", branch_cnt, 32'd5);
        idle(); repeat (2) tick();
        chk("t6.sticky", {31'd0, underflow_err}, 32'd1);
        idle(); setf(32'h100, 0, 0, 0, 0, 0, 0); tick();
        idle(); setf(32'h104, 0, 0, 0, 0, 0, 0); tick();
        idle(); setf(32'h108, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #3 RESET = 0;
        #1;
        chk_redirect("t6.rst", 0, 0, 32'h0);
        chk("t6.rst_under", {31'd0, underflow_err}, 32'd0);
        chk("t6.rst_branch", branch_cnt, 32'd0);
        chk("t6.rst_mispred", mispred_cnt, 32'd0);
        chk("t6.rst_hold", {31'd0, fetch_hold}, 32'd0);
        idle();
        @(negedge CLK) RESET = 1;
        tick();
        // chooser back to weak local (was strong global before reset)
        idle(); setf(32'h100, 1, 0, 1, 32'h200, 0, 0); tick();
        chk_redirect("t6.tbl_reset", 0, 1, 32'h200);
        idle(); setr(32'h100, 0, 0, 0); tick();
        idle(); repeat (2) tick();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
